svf_bias_ctrl: RTL and testbench
================================

SVF_BIAS_CTRL -- requirements
Module: svf_bias_ctrl

Interface
REQ-001 Parameter SLEW_DIV, default 16: clock cycles per one-LSB DAC code step; legal range 2..256.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  block enable; low freezes all state and deasserts cfg_ready.
REQ-005 cfg_valid  input  1  new filter configuration offered.
REQ-006 cfg_ready  output  1  configuration accepted on the same cycle cfg_valid is high; equals ena.
REQ-007 cfg_fc  input  11  SID-style cutoff register value.
REQ-008 cfg_res  input  4  SID-style resonance register value.
REQ-009 slew_bypass  input  1  when high, outputs jump directly to target.
REQ-010 d_fc  output  4  fc bias code to the bias DAC fc channel.
REQ-011 d_q  output  4  Q bias code to the bias DAC Q channel.
REQ-012 settled  output  1  high when both codes equal their targets.

Function
REQ-013 A transfer occurs on a rising edge with cfg_valid=1 and cfg_ready=1; the block then registers tgt_fc = cfg_fc[10:7] and tgt_q = 15 - cfg_res.
REQ-014 The FSM has two states: IDLE (settled=1) and SLEW (settled=0).
REQ-015 IDLE->SLEW on a transfer whose new target differs from the current code on either channel; a transfer with equal targets keeps IDLE.
REQ-016 SLEW->IDLE on the cycle both registered codes equal their targets; settled goes high on the following edge.
REQ-017 The prescaler clears to 0 on IDLE->SLEW and counts 0..SLEW_DIV-1 in SLEW, wrapping to 0; a tick is asserted when count = SLEW_DIV-1.
REQ-018 On each tick, each channel independently moves its code one LSB toward its target (+1 if below, -1 if above, hold if equal); codes never wrap.
REQ-019 The first step follows SLEW_DIV cycles after the accepting edge.
REQ-020 A transfer during SLEW retargets without clearing the prescaler; step direction is recomputed from the new target.
REQ-021 When a transfer and a tick coincide, the step uses the old target and the new target applies from the next cycle.
REQ-022 With slew_bypass=1, codes load their targets on the edge after the transfer; the FSM remains in or returns to IDLE.
REQ-023 Asserting slew_bypass during SLEW loads the targets on the next edge.
REQ-024 With ena=0, the prescaler, codes, targets and FSM hold their values and no transfer occurs.
REQ-025 d_fc, d_q and settled are driven directly from registers with no combinational path from inputs.

Reset
REQ-026 While rst_n=0: d_fc=0, d_q=15 (maximum damping, oscillation-safe), tgt_fc=0, tgt_q=15, prescaler=0, state=IDLE, settled=1.
REQ-027 Reset asserted mid-slew takes effect immediately and asynchronously; any pending target is lost.
REQ-028 The first transfer is possible on the first rising edge after rst_n deasserts with ena=1.

Structure
REQ-029 Package svf_bias_pkg holds the state enum, the reset codes (FC_RST=0, Q_RST=15) and the code width (4).
REQ-030 Sub-module slew_step (one channel: registered code, target compare, up/down step, bypass load) is instantiated twice; the FSM and prescaler sit in svf_bias_ctrl.

Verification (SLEW_DIV=4)
REQ-031 Reset -> d_fc=0, d_q=15, settled=1, and cfg_ready=ena.
REQ-032 Accept cfg_fc=11'h7FF, cfg_res=15 -> d_fc steps +1 every 4 cycles (first step 4 cycles after acceptance) to 15; d_q steps 15->0 in parallel; settled rises after the 15th step.
REQ-033 Accept cfg_fc=11'h400, cfg_res=0 from reset -> tgt_fc=8, tgt_q=15; only d_fc moves; settled is high after 8 ticks.
REQ-034 Mid-slew at d_fc=5 toward 15, accept cfg_fc=11'h100 (tgt=2) -> d_fc reverses to 4, 3, 2 with no prescaler restart; a transfer coincident with a tick applies the old direction for that step.
REQ-035 slew_bypass=1 with accept cfg_fc=11'h580 -> d_fc=11 on the next edge and settled stays 1; with ena=0 mid-slew, codes freeze, then resume on re-enable.
REQ-036 Accept a target equal to the current codes -> no SLEW entry and settled stays 1; rst_n pulsed mid-slew -> reset values appear immediately.

Source files
------------

// File: rtl/svf_bias_pkg.sv
// Shared types and constants for the SVF bias controller: FSM states,
// reset codes and the register-to-code mappings.
package svf_bias_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] FC_RST = 4'd0;
    localparam logic [CODE_W-1:0] Q_RST  = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLEW = 1'b1
    } state_t;

    // Only the top four cutoff bits reach the coarse fc DAC.
    function automatic logic [CODE_W-1:0] fc_target(input logic [10:0] fc);
        return fc[10:7];
    endfunction

    // Higher resonance means less damping, so the Q code runs inverted.
    function automatic logic [CODE_W-1:0] q_target(input logic [3:0] res);
        return 4'd15 - res;
    endfunction

endpackage

// File: rtl/svf_bias_ctrl_slew_step.sv
// One bias channel: target register, registered DAC code that moves one LSB
// toward the target per step, or loads it outright in bypass.
module slew_step
    import svf_bias_pkg::*;
#(
    parameter logic [CODE_W-1:0] RST_CODE = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load,
    input  logic [CODE_W-1:0] tgt_in,
    input  logic              step,
    input  logic              bypass,
    output logic [CODE_W-1:0] code,
    output logic              at_tgt
);

    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] tgt_r;

    // Target capture and code movement; steps use the target held before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r <= RST_CODE;
            tgt_r  <= RST_CODE;
        end else if (ena) begin
            if (load) begin
                tgt_r <= tgt_in;
            end else begin
                tgt_r <= tgt_r;
            end
            if (bypass) begin
                code_r <= tgt_r;
            end else if (step && (code_r < tgt_r)) begin
                code_r <= code_r + 4'd1;
            end else if (step && (code_r > tgt_r)) begin
                code_r <= code_r - 4'd1;
            end else begin
                code_r <= code_r;
            end
        end else begin
            code_r <= code_r;
            tgt_r  <= tgt_r;
        end
    end

    assign code   = code_r;
    assign at_tgt = (code_r == tgt_r);

endmodule

// File: rtl/svf_bias_ctrl.sv
// SID-style filter bias controller: accepts fc/resonance settings and slews
// two 4-bit bias DAC codes toward them at one LSB per SLEW_DIV cycles.
module svf_bias_ctrl
    import svf_bias_pkg::*;
#(
    parameter int SLEW_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [10:0]       cfg_fc,
    input  logic [3:0]        cfg_res,
    input  logic              slew_bypass,
    output logic [CODE_W-1:0] d_fc,
    output logic [CODE_W-1:0] d_q,
    output logic              settled
);

    localparam logic [7:0] DIV_LAST = 8'(SLEW_DIV - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_nxt_s;
    logic              settled_r;
    logic              transfer_s;
    logic              tick_s;
    logic [CODE_W-1:0] new_fc_s;
    logic [CODE_W-1:0] new_q_s;
    logic              fc_at_s;
    logic              q_at_s;
    logic              both_at_s;
    logic              tgt_differs_s;

    assign cfg_ready     = ena;
    assign transfer_s    = ena & cfg_valid;
    assign tick_s        = (state_r == ST_SLEW) && (cnt_r == DIV_LAST);
    assign new_fc_s      = fc_target(cfg_fc);
    assign new_q_s       = q_target(cfg_res);
    assign both_at_s     = fc_at_s & q_at_s;
    assign tgt_differs_s = (new_fc_s != d_fc) || (new_q_s != d_q);

    // Next-state and prescaler; IDLE re-enters SLEW if a bypass load was missed.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 8'd0;
                if (slew_bypass) begin
                    state_nxt_s = ST_IDLE;
                end else if (transfer_s) begin
                    state_nxt_s = tgt_differs_s ? ST_SLEW : ST_IDLE;
                end else begin
                    state_nxt_s = both_at_s ? ST_IDLE : ST_SLEW;
                end
            end
            ST_SLEW: begin
                if (slew_bypass || (!transfer_s && both_at_s)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = ST_SLEW;
                    cnt_nxt_s   = tick_s ? 8'd0 : (cnt_r + 8'd1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // FSM, prescaler and settled flag all freeze while the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            settled_r <= 1'b1;
        end else if (ena) begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            settled_r <= (state_nxt_s == ST_IDLE);
        end else begin
            state_r   <= state_r;
            cnt_r     <= cnt_r;
            settled_r <= settled_r;
        end
    end

    assign settled = settled_r;

    slew_step #(.RST_CODE(FC_RST)) u_fc (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .load   (transfer_s),
        .tgt_in (new_fc_s),
        .step   (tick_s),
        .bypass (slew_bypass),
        .code   (d_fc),
        .at_tgt (fc_at_s)
    );

    slew_step #(.RST_CODE(Q_RST)) u_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .load   (transfer_s),
        .tgt_in (new_q_s),
        .step   (tick_s),
        .bypass (slew_bypass),
        .code   (d_q),
        .at_tgt (q_at_s)
    );

endmodule

// File: tb/tb_svf_bias_ctrl.sv
// Scoreboard bench for svf_bias_ctrl with SLEW_DIV=4: expected {d_fc,d_q,settled}
// per cycle is computed from closed-form slew trajectories.
module tb_svf_bias_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [10:0] cfg_fc;
    logic [3:0]  cfg_res;
    logic        slew_bypass;
    logic [3:0]  d_fc;
    logic [3:0]  d_q;
    logic        settled;

    int          n_cmp;
    int          n_err;
    string       cur_tag;
    logic [8:0]  sb_q[$];

    svf_bias_ctrl #(.SLEW_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_fc      (cfg_fc),
        .cfg_res     (cfg_res),
        .slew_bypass (slew_bypass),
        .d_fc        (d_fc),
        .d_q         (d_q),
        .settled     (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int mv(input int s, input int t, input int k);
        int r;
        if (s < t) r = (s + k > t) ? t : s + k;
        else       r = (s - k < t) ? t : s - k;
        return r;
    endfunction

    // Expected samples for cycles c0..c1 after an accepting edge (c=0 is that edge).
    task automatic push_traj(input int sf, input int sq, input int tf, input int tq,
                             input int first, input int c0, input int c1);
        int k;
        int md;
        int df;
        int dq;
        logic st;
        df = (sf > tf) ? sf - tf : tf - sf;
        dq = (sq > tq) ? sq - tq : tq - sq;
        md = (df > dq) ? df : dq;
        for (int c = c0; c <= c1; c++) begin
            k  = (c >= first) ? ((c - first) / 4 + 1) : 0;
            st = (md == 0) ? 1'b1 : (c >= first + 4 * (md - 1) + 1);
            sb_q.push_back({4'(mv(sf, tf, k)), 4'(mv(sq, tq, k)), st});
        end
    endtask

    task automatic push_const(input int fc, input int q, input logic st, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back({4'(fc), 4'(q), st});
    endtask

    task automatic cyc();
        logic [8:0] exp;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check_val(cur_tag, {d_fc, d_q, settled}, exp);
        end
    endtask

    task automatic drive_cfg(input logic [10:0] fc, input logic [3:0] res, input int n);
        cfg_valid = 1'b1;
        cfg_fc    = fc;
        cfg_res   = res;
        cyc();
        cfg_valid = 1'b0;
        for (int i = 1; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_vals", {d_fc, d_q, settled}, {4'd0, 4'd15, 1'b1});
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0;
        cfg_fc = 11'd0; cfg_res = 4'd0; slew_bypass = 1'b0;
        cur_tag = "reset";
        #12;
        check_val("rst_vals", {d_fc, d_q, settled}, {4'd0, 4'd15, 1'b1});
        check_val("rdy_en", {8'd0, cfg_ready}, 9'd1);
        ena = 1'b0; #1;
        check_val("rdy_dis", {8'd0, cfg_ready}, 9'd0);
        ena = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        cur_tag = "full_slew";
        push_traj(0, 15, 15, 0, 4, 0, 64);
        drive_cfg(11'h7FF, 4'd15, 65);

        do_reset();
        cur_tag = "fc_only";
        push_traj(0, 15, 8, 15, 4, 0, 36);
        drive_cfg(11'h400, 4'd0, 37);

        do_reset();
        cur_tag = "retarget";
        push_traj(0, 15, 15, 15, 4, 0, 20);
        drive_cfg(11'h7FF, 4'd0, 21);
        push_traj(5, 15, 2, 15, 3, 0, 14);
        drive_cfg(11'h100, 4'd0, 15);

        do_reset();
        cur_tag = "retarget_tick";
        push_traj(0, 15, 15, 15, 4, 0, 19);
        drive_cfg(11'h7FF, 4'd0, 20);
        push_traj(5, 15, 2, 15, 4, 0, 16);
        drive_cfg(11'h100, 4'd0, 17);

        cur_tag = "bypass";
        slew_bypass = 1'b1;
        push_const(2, 15, 1'b1, 1);
        push_const(11, 0, 1'b1, 4);
        drive_cfg(11'h580, 4'd15, 3);
        slew_bypass = 1'b0;
        cyc(); cyc();

        cur_tag = "freeze";
        push_traj(11, 0, 0, 0, 4, 0, 9);
        drive_cfg(11'h000, 4'd15, 10);
        ena = 1'b0; cfg_valid = 1'b1; cfg_fc = 11'h7FF; cfg_res = 4'd0;
        for (int i = 0; i < 6; i++) begin
            push_const(9, 0, 1'b0, 1);
            cyc();
            check_val("frz_ready", {8'd0, cfg_ready}, 9'd0);
        end
        ena = 1'b1; cfg_valid = 1'b0;
        cur_tag = "resume";
        push_traj(11, 0, 0, 0, 4, 10, 50);
        for (int i = 0; i < 41; i++) cyc();

        cur_tag = "equal_tgt";
        push_traj(0, 0, 0, 0, 4, 0, 5);
        drive_cfg(11'h000, 4'd15, 6);

        cur_tag = "pre_rst";
        push_traj(0, 0, 15, 15, 4, 0, 9);
        drive_cfg(11'h7FF, 4'd0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst", {d_fc, d_q, settled}, {4'd0, 4'd15, 1'b1});
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur_tag = "post_rst";
        push_const(0, 15, 1'b1, 3);
        cyc(); cyc(); cyc();

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_left: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
